// File: rtl/vreg_bank_w_load.sv
// Register bank: DEPTH x WIDTH registers with one load port and two read ports.
// The read ports can be combinational or registered, and a load can optionally
// be bypassed to the read ports. A synchronous clear returns the whole bank to
// RESET_VAL. Addresses at or above DEPTH never write, and reads from them return zero.
module vreg_bank_w_load #(
    parameter int                 WIDTH     = 16,
    parameter int                 DEPTH     = 8,
    parameter int                 AW        = 3,
    parameter int                 BYPASS    = 1,
    parameter int                 READ_REG  = 0,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clear,
    input  logic             load,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] dout_a,
    output logic [WIDTH-1:0] dout_b,
    output logic             wr_ok
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             wr_ok_r;
    logic [DEPTH-1:0] wsel_s;
    logic             waddr_hit_s;
    logic             byp_en_s;
    logic [WIDTH-1:0] rv_a_s;
    logic [WIDTH-1:0] rv_b_s;

    // One-hot decode of the write address. Codes at or above DEPTH select no register.
    always_comb begin
        wsel_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (waddr == AW'(i)) begin
                wsel_s[i] = 1'b1;
            end else begin
                wsel_s[i] = 1'b0;
            end
        end
    end

    assign waddr_hit_s = |wsel_s;

    // A valid load is forwarded to the readers only when it is not cancelled by clear.
    assign byp_en_s = (BYPASS != 0) && load && !clear && waddr_hit_s;

    // Register storage. Clear has priority over load, and wr_ok reports whether the load was accepted.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= RESET_VAL;
            end
            wr_ok_r <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= RESET_VAL;
            end
            wr_ok_r <= 1'b0;
        end else if (load && waddr_hit_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wsel_s[i]) begin
                    mem_r[i] <= din;
                end
            end
            wr_ok_r <= 1'b1;
        end else begin
            wr_ok_r <= 1'b0;
        end
    end

    // Read muxes. Unmatched addresses fall through to zero, so unused codes never produce X.
    always_comb begin
        rv_a_s = {WIDTH{1'b0}};
        rv_b_s = {WIDTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (raddr_a == AW'(i)) begin
                if (byp_en_s && wsel_s[i]) begin
                    rv_a_s = din;
                end else begin
                    rv_a_s = mem_r[i];
                end
            end else begin
                rv_a_s = rv_a_s;
            end
            if (raddr_b == AW'(i)) begin
                if (byp_en_s && wsel_s[i]) begin
                    rv_b_s = din;
                end else begin
                    rv_b_s = mem_r[i];
                end
            end else begin
                rv_b_s = rv_b_s;
            end
        end
    end

    generate
        if (READ_REG != 0) begin : g_rd_reg
            logic [WIDTH-1:0] dout_a_r;
            logic [WIDTH-1:0] dout_b_r;

            // Output registers sample the read value. They see the pre-clear contents
            // on a clear cycle and follow the clear only after the next sample.
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    dout_a_r <= RESET_VAL;
                    dout_b_r <= RESET_VAL;
                end else begin
                    dout_a_r <= rv_a_s;
                    dout_b_r <= rv_b_s;
                end
            end

            assign dout_a = dout_a_r;
            assign dout_b = dout_b_r;
        end else begin : g_rd_comb
            assign dout_a = rv_a_s;
            assign dout_b = rv_b_s;
        end
    endgenerate

    assign wr_ok = wr_ok_r;

endmodule

// File: doc/vreg_bank_w_load.md
Name: vreg_bank_w_load

Overview:
- Parametrised successor to the single load-enabled register: a bank of DEPTH registers, each WIDTH bits wide.
- One load (write) port and two read ports.
- Read ports are combinational or registered, selected by parameter; optional write-to-read bypass; synchronous bulk clear.
- Serves as the datapath register file feeding ALU operands A and B.

Parameters:
- WIDTH, 16, data width of each register
- DEPTH, 8, number of registers (2..256; need not be a power of two)
- AW, 3, address width; must satisfy 2^AW >= DEPTH
- BYPASS, 1, 1 = a read of the address being loaded returns din in the same cycle; 0 = returns the old contents
- READ_REG, 0, 0 = combinational read outputs; 1 = read outputs registered, 1-cycle latency
- RESET_VAL, 0, value loaded into every register on reset or clear (WIDTH bits)

Ports:
- clock, in, 1, rising-edge clock
- resetn, in, 1, asynchronous active-low reset
- clear, in, 1, synchronous clear of all registers to RESET_VAL
- load, in, 1, write enable for register waddr
- waddr, in, AW, write address
- din, in, WIDTH, write data
- raddr_a, in, AW, read address, port A
- raddr_b, in, AW, read address, port B
- dout_a, out, WIDTH, read data, port A
- dout_b, out, WIDTH, read data, port B
- wr_ok, out, 1, registered flag: 1 when the previous cycle's load hit a valid address, else 0

Behaviour:
- Reset: resetn=0 asynchronously sets all registers to RESET_VAL, wr_ok=0, and (READ_REG=1) dout_a/dout_b=RESET_VAL. Takes effect immediately, independent of clock. Release is synchronous to the next rising edge, with no glitch on state.
- Update order at posedge clock, while resetn=1:
  - clear=1: all registers <= RESET_VAL. Clear beats load; the load is discarded and wr_ok <= 0.
  - else load=1 and waddr < DEPTH: reg[waddr] <= din; wr_ok <= 1.
  - else load=1 and waddr >= DEPTH: no state change; wr_ok <= 0.
  - else (load=0): all registers hold; wr_ok <= 0.
- Read value for a port with address r (rv):
  - r >= DEPTH: rv = 0.
  - BYPASS=1, load=1, clear=0, r == waddr < DEPTH: rv = din.
  - BYPASS=1, clear=1: rv = reg[r], the pre-clear contents (clear is not bypassed).
  - otherwise: rv = reg[r].
- READ_REG=0: dout = rv, combinational, zero latency.
- READ_REG=1: dout <= rv at posedge, so valid one cycle after the address is presented.
  - dout holds when nothing changes.
  - dout is not affected by clear until re-sampled.
- Both ports may read the same address at once; both return identical data.
- Write to address 0 is a normal write; no hardwired-zero register.
- Mid-operation resetn assertion overrides clear/load in that cycle. Registered outputs go to RESET_VAL at once.
- No X propagation from unused address codes. Out-of-range reads return all-zero regardless of RESET_VAL.

Test Plan:
- Reset with RESET_VAL=16'h0000: apply resetn=0 mid-cycle -> every register and dout_a/dout_b read 0 immediately, without waiting for an edge; wr_ok=0.
- Write/read, defaults: load=1, waddr=3, din=16'hBEEF; next cycle raddr_a=3, raddr_b=5 -> dout_a=16'hBEEF, dout_b=0, wr_ok=1.
- Bypass, BYPASS=1: reg[2]=16'h1111; same cycle load=1, waddr=2, din=16'h2222, raddr_a=2 -> dout_a=16'h2222 before the edge. With BYPASS=0 -> 16'h1111 before the edge and 16'h2222 after.
- Registered read, READ_REG=1: reg[4]=16'hA5A5; set raddr_b=4 at cycle n -> dout_b=16'hA5A5 at cycle n+1, not at n. Change raddr_b to 6 (value 0) -> dout_b=0 one cycle later.
- Clear priority: clear=1 and load=1, waddr=1, din=16'h7777 in the same cycle -> all registers = RESET_VAL afterwards, reg[1] != 16'h7777, wr_ok=0.
- Non-power-of-two depth, DEPTH=6, AW=3: load waddr=7, din=16'hFFFF -> no register changes, wr_ok=0; raddr_a=7 -> dout_a=0.
